// File: rtl/cpu_seq_if.sv
// Handshake/control bundle between the accumulator CPU sequencer and its datapath.
// Optional CPU_SEQ_WAIT_EN adds the memory-ready input.
interface cpu_seq_if;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
`ifdef CPU_SEQ_WAIT_EN
    logic       mem_rdy;
`endif
    logic       inc_pc;
    logic       load_pc;
    logic       load_ir;
    logic       load_acc;
    logic       alu_ena;
    logic       rd;
    logic       wr;
    logic       datactl_ena;
    logic       halt;

`ifdef CPU_SEQ_WAIT_EN
    modport master (output ena, opcode, zero, mem_rdy,
                    input  inc_pc, load_pc, load_ir, load_acc, alu_ena, rd, wr, datactl_ena, halt);
    modport slave  (input  ena, opcode, zero, mem_rdy,
                    output inc_pc, load_pc, load_ir, load_acc, alu_ena, rd, wr, datactl_ena, halt);
`else
    modport master (output ena, opcode, zero,
                    input  inc_pc, load_pc, load_ir, load_acc, alu_ena, rd, wr, datactl_ena, halt);
    modport slave  (input  ena, opcode, zero,
                    output inc_pc, load_pc, load_ir, load_acc, alu_ena, rd, wr, datactl_ena, halt);
`endif
endinterface

// File: rtl/cpu_sequencer.sv
// Eight-state fetch/execute controller for the 8-bit accumulator CPU.
// Define CPU_SEQ_WAIT_EN to stall memory-access states until mem_rdy.
module cpu_sequencer (
    input  logic      clk1,
    input  logic      rst,
    cpu_seq_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE, S0, S1, S2, S3, S4, S5, S6, S7, HALTED
    } state_e;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    state_e     state_q, state_d;
    logic [2:0] lop_q, lop_d;
    logic       memRdy;
    logic       isAluOp;
    logic       memAccess;
    logic       advance;

`ifdef CPU_SEQ_WAIT_EN
    assign memRdy = bus.mem_rdy;
`else
    assign memRdy = 1'b1;
`endif

    assign isAluOp = lop_q inside {3'b010, 3'b011, 3'b100, 3'b101};

    // States driving rd or wr are the only ones that wait for memory
    assign memAccess = (state_q == S0) || (state_q == S1) ||
                       (isAluOp && ((state_q == S4) || (state_q == S5) || (state_q == S6))) ||
                       ((lop_q == OP_STO) && (state_q == S5));
    assign advance   = memRdy || !memAccess;

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q <= IDLE;
            lop_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            lop_q   <= lop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lop_d   = lop_q;
        case (state_q)
            IDLE:    if (bus.ena) state_d = S0;
            S0:      if (advance) state_d = S1;
            S1:      if (advance) state_d = S2;
            S2: begin
                lop_d   = bus.opcode;
                state_d = S3;
            end
            S3:      state_d = (lop_q == OP_HLT) ? HALTED : S4;
            S4:      if (advance) state_d = S5;
            S5:      if (advance) state_d = S6;
            S6:      if (advance) state_d = S7;
            S7:      state_d = bus.ena ? S0 : IDLE;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    // Bus strobes stay up through a wait; register-load strobes fire once on the ready cycle
    always_comb begin
        bus.inc_pc      = 1'b0;
        bus.load_pc     = 1'b0;
        bus.load_ir     = 1'b0;
        bus.load_acc    = 1'b0;
        bus.alu_ena     = 1'b0;
        bus.rd          = 1'b0;
        bus.wr          = 1'b0;
        bus.datactl_ena = 1'b0;
        bus.halt        = 1'b0;
        case (state_q)
            S0, S1: begin
                bus.rd      = 1'b1;
                bus.load_ir = advance;
                bus.inc_pc  = advance;
            end
            S3: bus.halt = (lop_q == OP_HLT);
            S4: begin
                if (isAluOp) begin
                    bus.rd      = 1'b1;
                    bus.alu_ena = advance;
                end else if (lop_q == OP_STO) begin
                    bus.datactl_ena = 1'b1;
                end else if (lop_q == OP_JMP) begin
                    bus.load_pc = 1'b1;
                end
            end
            S5: begin
                if (isAluOp) begin
                    bus.rd       = 1'b1;
                    bus.load_acc = advance;
                end else if (lop_q == OP_STO) begin
                    bus.wr          = 1'b1;
                    bus.datactl_ena = 1'b1;
                end else if (lop_q == OP_JMP) begin
                    bus.load_pc = 1'b1;
                    bus.inc_pc  = 1'b1;
                end else if (lop_q == OP_SKZ) begin
                    bus.inc_pc = bus.zero;
                end
            end
            S6: begin
                if (isAluOp) begin
                    bus.rd = 1'b1;
                end else if (lop_q == OP_STO) begin
                    bus.datactl_ena = 1'b1;
                end
            end
            S7:      bus.inc_pc = (lop_q == OP_SKZ) && bus.zero;
            HALTED:  bus.halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed instructions, random instruction
// streams, halt, mid-instruction reset and (with CPU_SEQ_WAIT_EN) memory wait states.
module tb_cpu_sequencer;

    logic clk1 = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk1 = ~clk1;

    cpu_seq_if bus ();

    cpu_sequencer dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    // Output vector order: inc_pc load_pc load_ir load_acc alu_ena rd wr datactl_ena halt
    function automatic logic [8:0] observed();
        return {bus.inc_pc, bus.load_pc, bus.load_ir, bus.load_acc, bus.alu_ena,
                bus.rd, bus.wr, bus.datactl_ena, bus.halt};
    endfunction

    // Expected strobes for cycle k (0 = first fetch cycle) of an instruction
    function automatic logic [8:0] modelOut(input int k, input logic [2:0] op, input logic z);
        bit memOp = (op >= 3'd2) && (op <= 3'd5);
        bit sto   = (op == 3'd6);
        bit jmp   = (op == 3'd7);
        bit skz   = (op == 3'd1);
        bit inc = 0, lpc = 0, lir = 0, lacc = 0, alu = 0, rdv = 0, wrv = 0, dc = 0, h = 0;
        if (k == 0 || k == 1) begin
            rdv = 1; lir = 1; inc = 1;
        end
        if (k == 3 && op == 3'd0) h = 1;
        if (k == 4) begin
            if (memOp) begin rdv = 1; alu = 1; end
            if (sto)   dc  = 1;
            if (jmp)   lpc = 1;
        end
        if (k == 5) begin
            if (memOp) begin rdv = 1; lacc = 1; end
            if (sto)   begin wrv = 1; dc = 1; end
            if (jmp)   begin lpc = 1; inc = 1; end
            if (skz && z) inc = 1;
        end
        if (k == 6) begin
            if (sto)   dc  = 1;
            if (memOp) rdv = 1;
        end
        if (k == 7 && skz && z) inc = 1;
        return {inc, lpc, lir, lacc, alu, rdv, wrv, dc, h};
    endfunction

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic applyStimulus(input logic e, input logic [2:0] op, input logic z);
        bus.ena    = e;
        bus.opcode = op;
        bus.zero   = z;
    endtask

    task automatic checkOutput(input string tag, input logic [8:0] exp);
        checks++;
        assert (observed() === exp) else begin
            failures++;
            $error("FAIL %s: observed %b expected %b", tag, observed(), exp);
        end
    endtask

    task automatic checkCount(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // zmode: 0 = zero held low, 1 = held high, 2 = random per cycle
    task automatic runInstr(input logic [2:0] op, input bit fromIdle, input bit endEna,
                            input int zmode, input int resetAt);
        int   incs = 0;
        int   expInc;
        int   last = (op == 3'd0) ? 3 : 7;
        logic z, z5 = 1'b0, z7 = 1'b0;
        if (fromIdle) begin
            applyStimulus(1'b1, 3'($urandom), 1'($urandom));
            #1;
            checkOutput("idle_before_start", 9'b0);
            step();
        end
        for (int k = 0; k <= last; k++) begin
            z = (zmode == 2) ? 1'($urandom) : (zmode == 1);
            if (k == 5) z5 = z;
            if (k == 7) z7 = z;
            applyStimulus((k == last) ? endEna : 1'($urandom),
                          (k == 2) ? op : 3'($urandom), z);
            #1;
            checkOutput($sformatf("op%0d_cycle%0d", op, k), modelOut(k, op, z));
            if (bus.inc_pc === 1'b1) incs++;
            if (k == resetAt) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                applyStimulus(1'b0, 3'($urandom), 1'($urandom));
                #1;
                checkOutput("after_mid_reset", 9'b0);
                return;
            end
            step();
        end
        if (op != 3'd0) begin
            expInc = 2 + ((op == 3'd7) ? 1 : 0) + ((op == 3'd1) ? (int'(z5) + int'(z7)) : 0);
            checkCount($sformatf("op%0d_inc_pc_total", op), incs, expInc);
        end
    endtask

    initial begin
        bit prevEna;
        bit endEna;
        rst = 1'b1;
        applyStimulus(1'b0, 3'b000, 1'b0);
`ifdef CPU_SEQ_WAIT_EN
        bus.mem_rdy = 1'b1;
`endif
        step();
        step();
        rst = 1'b0;
        #1;
        checkOutput("reset_state", 9'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("idle_hold", 9'b0);
        end

        runInstr(3'd2, 1'b1, 1'b1, 2, -1);
        runInstr(3'd6, 1'b0, 1'b1, 2, -1);
        runInstr(3'd1, 1'b0, 1'b1, 1, -1);
        runInstr(3'd1, 1'b0, 1'b1, 0, -1);
        runInstr(3'd7, 1'b0, 1'b0, 2, -1);

        prevEna = 1'b0;
        for (int i = 0; i < 40; i++) begin
            endEna = (i == 39) ? 1'b0 : 1'($urandom);
            runInstr(3'($urandom_range(1, 7)), !prevEna, endEna, 2, -1);
            prevEna = endEna;
        end

        runInstr(3'd2, 1'b1, 1'b1, 2, 5);

        runInstr(3'd0, 1'b1, 1'b1, 2, -1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 3'($urandom), 1'($urandom));
            #1;
            checkOutput("halted_hold", 9'b000000001);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        applyStimulus(1'b0, 3'b000, 1'b0);
        #1;
        checkOutput("halt_cleared_by_reset", 9'b0);
        step();
        checkOutput("idle_after_halt_reset", 9'b0);

`ifdef CPU_SEQ_WAIT_EN
        applyStimulus(1'b1, 3'b010, 1'b0);
        step();
        bus.mem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("wait_s0_cycle%0d", i), 9'b000001000);
            step();
        end
        bus.mem_rdy = 1'b1;
        #1;
        checkOutput("wait_s0_ready", 9'b101001000);
        step();
        checkOutput("wait_s1_after_release", 9'b101001000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checkOutput("wait_reset", 9'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
